uart_result_streamer: RTL and testbench



---
 rtl/uart_result_streamer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_result_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_streamer.sv
// Ships a DIM x DIM result tile to a UART transmitter: header byte, then each element MSB first.
// Define STREAMER_CHECKSUM_EN to append a mod-256 sum of the data bytes after the last data byte.
module uart_result_streamer #(
  parameter int         DIM    = 4,
  parameter int         ELEM_W = 16,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ELEM_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_status,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state_dbg
);
  localparam int N     = DIM * DIM;
  localparam int BPE   = ELEM_W / 8;
  localparam int CNT_W = $clog2(N + 1);
  localparam int BI_W  = (BPE > 1) ? $clog2(BPE) : 1;

  // Transmitter handshake: a byte is offered only while tx_status=1; tx_load is a single-cycle
  // strobe, the byte counts as taken once tx_status falls, and the transmitter is free again when
  // tx_status rises. tx_data is held from the load strobe until that rise.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISSUE     = 4'd1,
    S_WAIT_ACK  = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_NEXT      = 4'd4,
    S_FETCH     = 4'd5,
    S_LATCH     = 4'd6,
`ifdef STREAMER_CHECKSUM_EN
    S_CKSUM     = 4'd7,
`endif
    S_FINISH    = 4'd8
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  elem_idx, elem_idx_d;
  logic [BI_W-1:0]   byte_idx, byte_idx_d;
  logic [ELEM_W-1:0] sh, sh_d, sh_shift;
  logic [7:0]        tx_data_d;
  logic              tx_load_d, mem_rd_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              more_bytes, more_elems;
`ifdef STREAMER_CHECKSUM_EN
  logic [7:0]        cksum, cksum_d;
  logic              is_data, is_data_d, cksum_sent, cksum_sent_d;
`endif

  assign more_bytes = (byte_idx != BI_W'(BPE - 1));
  assign more_elems = (elem_idx != CNT_W'(N));
  assign sh_shift   = sh << 8;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      elem_idx   <= '0;
      byte_idx   <= '0;
      sh         <= '0;
      tx_data    <= 8'h00;
      tx_load    <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
      cksum      <= 8'h00;
      is_data    <= 1'b0;
      cksum_sent <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      elem_idx   <= elem_idx_d;
      byte_idx   <= byte_idx_d;
      sh         <= sh_d;
      tx_data    <= tx_data_d;
      tx_load    <= tx_load_d;
      mem_rd_en  <= mem_rd_en_d;
      mem_addr   <= mem_addr_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef STREAMER_CHECKSUM_EN
      cksum      <= cksum_d;
      is_data    <= is_data_d;
      cksum_sent <= cksum_sent_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (start) state_d = S_ISSUE;
      S_ISSUE:     if (tx_status) state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (!tx_status) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_status) state_d = S_NEXT;
      S_NEXT: begin
        if (more_bytes)      state_d = S_ISSUE;
        else if (more_elems) state_d = S_FETCH;
`ifdef STREAMER_CHECKSUM_EN
        else if (!cksum_sent) state_d = S_CKSUM;
`endif
        else                 state_d = S_FINISH;
      end
      S_FETCH:     state_d = S_LATCH;
      S_LATCH:     state_d = S_ISSUE;
`ifdef STREAMER_CHECKSUM_EN
      S_CKSUM:     state_d = S_ISSUE;
`endif
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output; done/busy change on entry to FINISH so that done
  // is high only while in FINISH, where start is not sampled.
  always_comb begin
    elem_idx_d   = elem_idx;
    byte_idx_d   = byte_idx;
    sh_d         = sh;
    tx_data_d    = tx_data;
    tx_load_d    = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr;
    busy_d       = busy;
    done_d       = 1'b0;
`ifdef STREAMER_CHECKSUM_EN
    cksum_d      = cksum;
    is_data_d    = is_data;
    cksum_sent_d = cksum_sent;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          tx_data_d    = HEADER;
          elem_idx_d   = '0;
          byte_idx_d   = BI_W'(BPE - 1);
`ifdef STREAMER_CHECKSUM_EN
          cksum_d      = 8'h00;
          is_data_d    = 1'b0;
          cksum_sent_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (tx_status) begin
          tx_load_d = 1'b1;
`ifdef STREAMER_CHECKSUM_EN
          if (is_data) cksum_d = cksum + tx_data;
`endif
        end
      end
      S_NEXT: begin
        if (more_bytes) begin
          sh_d       = sh_shift;
          tx_data_d  = sh_shift[ELEM_W-1 -: 8];
          byte_idx_d = byte_idx + 1'b1;
        end else if (more_elems) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = ADDR_W'(elem_idx);
        end
`ifdef STREAMER_CHECKSUM_EN
        else if (!cksum_sent) begin
          busy_d = 1'b1;
        end
`endif
        else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      S_LATCH: begin
        sh_d       = mem_rdata;
        tx_data_d  = mem_rdata[ELEM_W-1 -: 8];
        elem_idx_d = elem_idx + 1'b1;
        byte_idx_d = '0;
`ifdef STREAMER_CHECKSUM_EN
        is_data_d  = 1'b1;
`endif
      end
`ifdef STREAMER_CHECKSUM_EN
      S_CKSUM: begin
        tx_data_d    = cksum;
        is_data_d    = 1'b0;
        cksum_sent_d = 1'b1;
      end
`endif
      default: begin
        tx_load_d = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_result_streamer.sv
// Directed plus randomized frames for uart_result_streamer against a behavioural transmitter,
// a one-cycle-latency result buffer and a byte-level frame model.
module tb_uart_result_streamer;
  localparam int DIM    = 2;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 4;
  localparam int N      = DIM * DIM;
  localparam int BPE    = ELEM_W / 8;
`ifdef STREAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 2 + N * BPE;
`else
  localparam int FRAME_LEN = 1 + N * BPE;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic              tx_status;
  logic              busy;
  logic              done;
  logic [3:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  uart_result_streamer #(.DIM(DIM), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_load(tx_load), .tx_status(tx_status),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // result buffer: data valid one cycle after the read strobe
  logic [ELEM_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // transmitter: status drops the cycle after load and stays low busy_len cycles
  int busy_len = 20;
  int tx_cnt   = 0;
  bit ext_hold = 1'b0;
  always @(posedge clk) begin
    if (tx_load) tx_cnt <= busy_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_status = (tx_cnt == 0) && !ext_hold;

  // monitor
  bit                mon_clr = 1'b0;
  logic [7:0]        act_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                rd_load_q[$];
  int                load_cnt, hold_viol, dbl_load, dbl_rd, done_cnt;
  bit                prev_load, prev_rd, holding;
  logic [7:0]        held;
  always @(negedge clk) begin
    if (reset || mon_clr) begin
      act_q.delete(); rd_addr_q.delete(); rd_load_q.delete();
      load_cnt = 0; hold_viol = 0; dbl_load = 0; dbl_rd = 0; done_cnt = 0;
      prev_load = 1'b0; prev_rd = 1'b0; holding = 1'b0; held = 8'h00;
    end else begin
      if (tx_load) begin
        act_q.push_back(tx_data);
        load_cnt++;
        if (prev_load) dbl_load++;
        held = tx_data;
        holding = 1'b1;
      end else if (holding) begin
        if (tx_data !== held) hold_viol++;
        if (tx_status) holding = 1'b0;
      end
      if (mem_rd_en) begin
        rd_addr_q.push_back(mem_addr);
        rd_load_q.push_back(load_cnt);
        if (prev_rd) dbl_rd++;
      end
      if (done) done_cnt++;
      prev_load = tx_load;
      prev_rd   = mem_rd_en;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp();
    logic [ELEM_W-1:0] w;
`ifdef STREAMER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int e = 0; e < N; e++) begin
      for (int b = BPE - 1; b >= 0; b--) begin
        w = mem[e] >> (8 * b);
        exp_q.push_back(w[7:0]);
`ifdef STREAMER_CHECKSUM_EN
        sum = sum + w[7:0];
`endif
      end
    end
`ifdef STREAMER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin step(1); n++; end
    check({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
    step(3);
  endtask

  task automatic check_frame(input string tag);
    build_exp();
    check({tag, "_len"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    check({tag, "_loads"}, load_cnt, FRAME_LEN);
    check({tag, "_hold"}, hold_viol, 0);
    check({tag, "_dbl_load"}, dbl_load, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_nreads"}, rd_addr_q.size(), N);
    for (int k = 0; k < N && k < rd_addr_q.size(); k++) begin
      check($sformatf("%s_rd_addr%0d", tag, k), 32'(rd_addr_q[k]), k);
      check($sformatf("%s_rd_before%0d", tag, k), rd_load_q[k], 1 + k * BPE);
    end
    check({tag, "_dbl_rd"}, dbl_rd, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_load"}, 32'(tx_load), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
    step(3);
    check_reset_outputs("reset");
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step(2);

    // baseline frame
    clear_mon();
    pulse_start();
    check("base_busy_rise", 32'(busy), 32'd1);
    wait_done("base");
    check_frame("base");

    // transmitter externally busy at the header
    ext_hold = 1'b1;
    clear_mon();
    pulse_start();
    step(50);
    check("ext_no_load", load_cnt, 0);
    ext_hold = 1'b0;
    wait_done("ext");
    check_frame("ext");

    // start while busy is ignored
    clear_mon();
    pulse_start();
    n = 0;
    while (load_cnt < 3 && n < 2000) begin step(1); n++; end
    check("mid_start_reach", 32'(load_cnt >= 3), 32'd1);
    pulse_start();
    wait_done("mid");
    step(60);
    check_frame("mid");

    // asynchronous reset during WAIT_DONE of byte 5
    clear_mon();
    pulse_start();
    n = 0;
    while (!(load_cnt >= 5 && !tx_status) && n < 2000) begin step(1); n++; end
    check("rst_reach", 32'(load_cnt >= 5), 32'd1);
    step(3);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    step(2);
    reset = 1'b0;
    clear_mon();
    pulse_start();
    wait_done("post_rst");
    check_frame("post_rst");

    // randomized tiles and transmitter speeds
    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < N; e++) mem[e] = ELEM_W'($urandom_range(0, 65535));
      busy_len = $urandom_range(2, 30);
      step($urandom_range(0, 5));
      clear_mon();
      pulse_start();
      wait_done($sformatf("rand%0d", r));
      check_frame($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
